// File: rtl/alu_if_pkg.sv
// Shared definitions for the ALU operand interface: default widths, opcode map,
// issuer FSM states and a golden model of the ALU.
package alu_if_pkg;
    localparam int W_DEF     = 4;
    localparam int OPC_W_DEF = 3;
    localparam int RES_W_DEF = 5;

    typedef enum logic [2:0] {
        OPC_ADD = 3'd0,
        OPC_SUB = 3'd1,
        OPC_AND = 3'd2,
        OPC_OR  = 3'd3,
        OPC_XOR = 3'd4,
        OPC_NOT = 3'd5,
        OPC_SHL = 3'd6,
        OPC_SHR = 3'd7
    } alu_opc_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

    function automatic logic [RES_W_DEF-1:0] alu_ref(
        input logic [W_DEF-1:0]     op1,
        input logic [W_DEF-1:0]     op2,
        input logic [OPC_W_DEF-1:0] opc
    );
        logic [RES_W_DEF-1:0] a, b, r;
        logic [W_DEF-1:0]     n;
        a = RES_W_DEF'(op1);
        b = RES_W_DEF'(op2);
        // invert at operand width so the upper result bits stay zero
        n = ~op1;
        case (opc)
            OPC_ADD: r = a + b;
            OPC_SUB: r = a - b;
            OPC_AND: r = a & b;
            OPC_OR:  r = a | b;
            OPC_XOR: r = a ^ b;
            OPC_NOT: r = RES_W_DEF'(n);
            OPC_SHL: r = a << 1;
            OPC_SHR: r = a >> 1;
            default: r = '0;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/alu_lat_counter.sv
// Fixed-latency down counter: load a start value, decrement to zero, flag zero.
module alu_lat_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/alu_op_issuer.sv
// Initiator of the ALU operand interface: one operation in flight, operands held for
// ALU_LAT cycles, result returned on a response stream. Optional checker: ALU_OP_ISSUER_CHECK_EN.
module alu_op_issuer #(
    parameter int W       = alu_if_pkg::W_DEF,
    parameter int OPC_W   = alu_if_pkg::OPC_W_DEF,
    parameter int RES_W   = alu_if_pkg::RES_W_DEF,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_op1,
    input  logic [W-1:0]     cmd_op2,
    input  logic [OPC_W-1:0] cmd_opcode,
    output logic [W-1:0]     alu_op1,
    output logic [W-1:0]     alu_op2,
    output logic [OPC_W-1:0] alu_opcode,
    output logic             alu_start,
    input  logic [RES_W-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic [OPC_W-1:0] rsp_opcode,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
`ifdef ALU_OP_ISSUER_CHECK_EN
    ,
    output logic             chk_err,
    output logic [7:0]       chk_err_cnt
`endif
);
    import alu_if_pkg::*;

    localparam int LAT_W = 4;

    issuer_state_e    state_q, state_d;
    logic [W-1:0]     alu_op1_q, alu_op1_d;
    logic [W-1:0]     alu_op2_q, alu_op2_d;
    logic [OPC_W-1:0] alu_opcode_q, alu_opcode_d;
    logic             alu_start_q, alu_start_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0] rsp_result_q, rsp_result_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             capture;

    alu_lat_counter #(.CW(LAT_W)) u_lat_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (LAT_W'(ALU_LAT - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign capture = (state_q == ST_WAIT) && cnt_zero;

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_opcode_d = alu_opcode_q;
        alu_start_d  = 1'b0;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        busy_d       = busy_q;
        ops_done_d   = ops_done_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_op1_d    = cmd_op1;
                    alu_op2_d    = cmd_op2;
                    alu_opcode_d = cmd_opcode;
                    alu_start_d  = 1'b1;
                    cmd_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture) begin
                    rsp_result_d = alu_result;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_opcode_q <= '0;
            alu_start_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_opcode_q <= alu_opcode_d;
            alu_start_q  <= alu_start_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_start  = alu_start_q;
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    // operands are frozen until the next accept, so they name the pending result
    assign rsp_opcode = alu_opcode_q;
    assign busy       = busy_q;
    assign ops_done   = ops_done_q;

`ifdef ALU_OP_ISSUER_CHECK_EN
    logic       chk_err_q, chk_err_d;
    logic [7:0] chk_err_cnt_q, chk_err_cnt_d;
    logic       chk_mis;

    assign chk_mis = (alu_result != RES_W'(alu_ref(W_DEF'(alu_op1_q), W_DEF'(alu_op2_q),
                                                    OPC_W_DEF'(alu_opcode_q))));

    always_comb begin
        chk_err_d     = chk_err_q;
        chk_err_cnt_d = chk_err_cnt_q;
        if (capture && chk_mis) begin
            chk_err_d = 1'b1;
            if (chk_err_cnt_q != 8'hFF)
                chk_err_cnt_d = chk_err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            chk_err_q     <= 1'b0;
            chk_err_cnt_q <= '0;
        end else begin
            chk_err_q     <= chk_err_d;
            chk_err_cnt_q <= chk_err_cnt_d;
        end
    end

    assign chk_err     = chk_err_q;
    assign chk_err_cnt = chk_err_cnt_q;
`endif
endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: two instances (ALU_LAT=1 and ALU_LAT=3), each fed by a stub ALU
// that returns a poison value until its latency has elapsed.
module tb_alu_op_issuer;
    localparam int NI = 2;
    localparam logic [4:0] POISON = 5'h15;

    logic       clk, rstn;
    logic       cmd_valid [NI];
    logic       cmd_ready [NI];
    logic [3:0] cmd_op1 [NI], cmd_op2 [NI];
    logic [2:0] cmd_opcode [NI];
    logic [3:0] alu_op1 [NI], alu_op2 [NI];
    logic [2:0] alu_opcode [NI];
    logic       alu_start [NI];
    logic [4:0] alu_result [NI];
    logic       rsp_valid [NI], rsp_ready [NI];
    logic [4:0] rsp_result [NI];
    logic [2:0] rsp_opcode [NI];
    logic       busy [NI];
    logic [15:0] ops_done [NI];
    logic       chk_err [NI];
    logic [7:0] chk_err_cnt [NI];
    logic       stub_bad [NI];
    int         scnt [NI];
    int         done_cnt [NI];
    int         cyc = 0;
    int         n_cmp = 0, n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // ALU behaviour from the opcode table, in plain integer arithmetic.
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] opc);
        int x, y, r;
        x = int'(a);
        y = int'(b);
        case (opc)
            3'd0: r = x + y;
            3'd1: r = x - y + 32;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = 15 - x;
            3'd6: r = x * 2;
            3'd7: r = x / 2;
            default: r = 0;
        endcase
        return r[4:0];
    endfunction

    always @(posedge clk)
        for (int k = 0; k < NI; k++) begin
            if (alu_start[k]) scnt[k] <= 1;
            else if (scnt[k] < 100) scnt[k] <= scnt[k] + 1;
        end

    always_comb
        for (int k = 0; k < NI; k++) begin
            alu_result[k] = (scnt[k] >= lat_of(k)) ? model(alu_op1[k], alu_op2[k], alu_opcode[k]) : POISON;
            if (stub_bad[k]) alu_result[k] = 5'h00;
        end

    alu_op_issuer #(.ALU_LAT(1)) u_dut_l1 (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op1(cmd_op1[0]), .cmd_op2(cmd_op2[0]), .cmd_opcode(cmd_opcode[0]),
        .alu_op1(alu_op1[0]), .alu_op2(alu_op2[0]), .alu_opcode(alu_opcode[0]),
        .alu_start(alu_start[0]), .alu_result(alu_result[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .rsp_opcode(rsp_opcode[0]),
        .busy(busy[0]), .ops_done(ops_done[0])
`ifdef ALU_OP_ISSUER_CHECK_EN
        , .chk_err(chk_err[0]), .chk_err_cnt(chk_err_cnt[0])
`endif
    );

    alu_op_issuer #(.ALU_LAT(3)) u_dut_l3 (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op1(cmd_op1[1]), .cmd_op2(cmd_op2[1]), .cmd_opcode(cmd_opcode[1]),
        .alu_op1(alu_op1[1]), .alu_op2(alu_op2[1]), .alu_opcode(alu_opcode[1]),
        .alu_start(alu_start[1]), .alu_result(alu_result[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .rsp_opcode(rsp_opcode[1]),
        .busy(busy[1]), .ops_done(ops_done[1])
`ifdef ALU_OP_ISSUER_CHECK_EN
        , .chk_err(chk_err[1]), .chk_err_cnt(chk_err_cnt[1])
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d]: got %0h, expected %0h (cycle %0d)", nm, k, act, exp, cyc);
        end
    endtask

    // One full transaction from IDLE, with `stall` cycles of response backpressure.
    task automatic run_op(input int k, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] opc, input int stall, input logic [4:0] exp);
        int n;
        cmd_op1[k] = a; cmd_op2[k] = b; cmd_opcode[k] = opc; cmd_valid[k] = 1'b1;
        n = 0;
        while (!cmd_ready[k] && n < 40) begin tick(); n++; end
        chk("accept_ready", k, 32'(cmd_ready[k]), 1);
        tick();
        cmd_valid[k] = 1'b0;
        cmd_op1[k] = 4'($urandom); cmd_op2[k] = 4'($urandom); cmd_opcode[k] = 3'($urandom);
        chk("alu_start", k, 32'(alu_start[k]), 1);
        chk("busy_hi", k, 32'(busy[k]), 1);
        chk("cmd_ready_lo", k, 32'(cmd_ready[k]), 0);
        chk("alu_op1", k, 32'(alu_op1[k]), 32'(a));
        chk("alu_op2", k, 32'(alu_op2[k]), 32'(b));
        chk("alu_opcode", k, 32'(alu_opcode[k]), 32'(opc));
        for (int i = 0; i < lat_of(k); i++) begin
            tick();
            chk("start_one_cycle", k, 32'(alu_start[k]), 0);
            chk("rsp_not_early", k, 32'(rsp_valid[k]), 0);
        end
        tick();
        chk("rsp_valid", k, 32'(rsp_valid[k]), 1);
        chk("rsp_result", k, 32'(rsp_result[k]), 32'(exp));
        chk("rsp_opcode", k, 32'(rsp_opcode[k]), 32'(opc));
        chk("op_stable", k, 32'(alu_op1[k]), 32'(a));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("hold_valid", k, 32'(rsp_valid[k]), 1);
            chk("hold_result", k, 32'(rsp_result[k]), 32'(exp));
            chk("hold_cmd_ready", k, 32'(cmd_ready[k]), 0);
        end
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready[k] = 1'b0;
        done_cnt[k] = (done_cnt[k] + 1) & 16'hFFFF;
        chk("rsp_drop", k, 32'(rsp_valid[k]), 0);
        chk("idle_ready", k, 32'(cmd_ready[k]), 1);
        chk("busy_lo", k, 32'(busy[k]), 0);
        chk("ops_done", k, 32'(ops_done[k]), 32'(done_cnt[k]));
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic [2:0] opc;
        int         stall;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] ba [3];
        logic [3:0] bb [3];
        logic [2:0] bo [3];
        logic [4:0] be [3];
        logic [4:0] got [$];
        int acc_cyc [3];
        int idx, n;
        logic acc;

        tbl[0] = '{4'h3, 4'h5, 3'd0, 0, 5'h08};
        tbl[1] = '{4'h2, 4'h5, 3'd1, 4, 5'h1D};
        tbl[2] = '{4'hF, 4'h8, 3'd2, 1, 5'h08};
        tbl[3] = '{4'hA, 4'h5, 3'd3, 0, 5'h0F};
        tbl[4] = '{4'hC, 4'hA, 3'd4, 2, 5'h06};
        tbl[5] = '{4'h5, 4'h0, 3'd5, 0, 5'h0A};
        tbl[6] = '{4'h9, 4'h0, 3'd6, 0, 5'h12};
        tbl[7] = '{4'h9, 4'h0, 3'd7, 0, 5'h04};
        tbl[8] = '{4'hF, 4'hF, 3'd0, 0, 5'h1E};
        tbl[9] = '{4'h0, 4'h1, 3'd1, 3, 5'h1F};

        rstn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            cmd_valid[k] = 1'b1; cmd_op1[k] = 4'h7; cmd_op2[k] = 4'h6; cmd_opcode[k] = 3'd0;
            rsp_ready[k] = 1'b0; stub_bad[k] = 1'b0; done_cnt[k] = 0;
        end
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("rst_cmd_ready", k, 32'(cmd_ready[k]), 1);
            chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 0);
            chk("rst_alu_start", k, 32'(alu_start[k]), 0);
            chk("rst_ops_done", k, 32'(ops_done[k]), 0);
            chk("rst_busy", k, 32'(busy[k]), 0);
            chk("rst_alu_op1", k, 32'(alu_op1[k]), 0);
            chk("rst_rsp_result", k, 32'(rsp_result[k]), 0);
            cmd_valid[k] = 1'b0;
        end
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++)
            run_op(0, tbl[i].a, tbl[i].b, tbl[i].opc, tbl[i].stall, tbl[i].exp);

        // Back-to-back on the LAT=3 instance with cmd_valid and rsp_ready held high.
        ba = '{4'hF, 4'h0, 4'hF}; bb = '{4'h8, 4'h0, 4'hF};
        bo = '{3'd2, 3'd3, 3'd4}; be = '{5'h08, 5'h00, 5'h00};
        idx = 0; n = 0;
        cmd_op1[1] = ba[0]; cmd_op2[1] = bb[0]; cmd_opcode[1] = bo[0];
        cmd_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
        while ((idx < 3 || got.size() < 3) && n < 100) begin
            acc = cmd_valid[1] && cmd_ready[1];
            if (rsp_valid[1]) got.push_back(rsp_result[1]);
            tick();
            n++;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    cmd_op1[1] = ba[idx]; cmd_op2[1] = bb[idx]; cmd_opcode[1] = bo[idx];
                end else begin
                    cmd_valid[1] = 1'b0;
                end
            end
        end
        tick();
        rsp_ready[1] = 1'b0;
        chk("b2b_in_budget", 1, 32'(n < 100), 1);
        if (idx == 3) begin
            chk("b2b_spacing01", 1, 32'(acc_cyc[1] - acc_cyc[0]), 6);
            chk("b2b_spacing12", 1, 32'(acc_cyc[2] - acc_cyc[1]), 6);
        end
        for (int i = 0; i < 3; i++) begin
            if (got.size() > i) chk("b2b_result", 1, 32'(got[i]), 32'(be[i]));
            else chk("b2b_result_missing", 1, 0, 1);
        end
        done_cnt[1] = done_cnt[1] + 3;
        chk("b2b_ops_done", 1, 32'(ops_done[1]), 32'(done_cnt[1]));

        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 25; i++) begin
                logic [3:0] ra, rb;
                logic [2:0] ro;
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                ro = 3'($urandom_range(0, 7));
                run_op(k, ra, rb, ro, $urandom_range(0, 3), model(ra, rb, ro));
                repeat ($urandom_range(0, 2)) tick();
            end

`ifdef ALU_OP_ISSUER_CHECK_EN
        chk("chk_err_clean", 0, 32'(chk_err[0]), 0);
        stub_bad[0] = 1'b1;
        run_op(0, 4'h1, 4'h1, 3'd0, 0, 5'h00);
        stub_bad[0] = 1'b0;
        chk("chk_err_set", 0, 32'(chk_err[0]), 1);
        chk("chk_err_cnt1", 0, 32'(chk_err_cnt[0]), 1);
        run_op(0, 4'h2, 4'h2, 3'd0, 0, 5'h04);
        chk("chk_err_sticky", 0, 32'(chk_err[0]), 1);
        chk("chk_err_cnt_hold", 0, 32'(chk_err_cnt[0]), 1);
`endif

        // Reset while the LAT=3 instance is in WAIT.
        cmd_op1[1] = 4'h7; cmd_op2[1] = 4'h7; cmd_opcode[1] = 3'd0; cmd_valid[1] = 1'b1;
        tick();
        cmd_valid[1] = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        done_cnt[0] = 0; done_cnt[1] = 0;
        chk("midrst_busy", 1, 32'(busy[1]), 0);
        chk("midrst_cmd_ready", 1, 32'(cmd_ready[1]), 1);
        chk("midrst_ops_done", 1, 32'(ops_done[1]), 0);
        chk("midrst_ops_done_l1", 0, 32'(ops_done[0]), 0);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_rsp", 1, 32'(rsp_valid[1]), 0);
            tick();
        end
        run_op(1, 4'h6, 4'h3, 3'd1, 0, 5'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
